// File: rtl/bless_port_alloc.sv
// BLESS output-port allocator: oldest-first ranking, one eject per cycle, productive-else-deflect port choice.
// Latency 1 cycle (registered outputs); never stalls in_*, injection gated only by inj_ready.
module bless_port_alloc (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  addrx,
  input  logic [1:0]  addry,
  input  logic [12:0] in_n,
  input  logic [12:0] in_s,
  input  logic [12:0] in_e,
  input  logic [12:0] in_w,
  input  logic [3:0]  rm_n,
  input  logic [3:0]  rm_s,
  input  logic [3:0]  rm_e,
  input  logic [3:0]  rm_w,
  input  logic [12:0] inj_flit,
  input  logic [3:0]  inj_rm,
  input  logic        inj_valid,
  output logic        inj_ready,
  output logic [12:0] out_n,
  output logic [12:0] out_s,
  output logic [12:0] out_e,
  output logic [12:0] out_w,
  output logic [12:0] eject_flit,
  output logic [15:0] deflect_count
);
  localparam int NP = 4;

  logic [12:0]   fl      [NP];
  logic [3:0]    rm      [NP];
  logic [1:0]    rank    [NP];
  logic [12:0]   out_d   [NP];
  logic [12:0]   out_q   [NP];
  logic [NP-1:0] vld;
  logic [NP-1:0] loc;
  logic [12:0]   eject_d, eject_q;
  logic [15:0]   defl_d, defl_q;
  logic [16:0]   defl_sum;
  logic [2:0]    ndefl;
  logic [3:0]    free, prod;
  logic [1:0]    port;
  logic          ej_free;
  logic          inj_go;
  logic          unused_inj_bits;

  assign fl[0] = in_n;
  assign fl[1] = in_s;
  assign fl[2] = in_e;
  assign fl[3] = in_w;
  assign rm[0] = rm_n;
  assign rm[1] = rm_s;
  assign rm[2] = rm_e;
  assign rm[3] = rm_w;

  // Injected flits get a fresh age and a forced valid bit, so these fields are don't-care.
  assign unused_inj_bits = ^{inj_flit[12], inj_flit[3:0]};

  function automatic logic [1:0] first_set(input logic [3:0] m);
    first_set = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) first_set = 2'(k);
    end
  endfunction

  // a outranks b: older, then lower src, then earlier port position.
  function automatic logic beats(input logic [12:0] a, input logic [12:0] b, input logic a_first);
    beats = (a[3:0] > b[3:0]) ||
            ((a[3:0] == b[3:0]) && ((a[11:8] < b[11:8]) || ((a[11:8] == b[11:8]) && a_first)));
  endfunction

  function automatic logic [12:0] age_inc(input logic [12:0] f);
    age_inc = {f[12:4], (f[3:0] == 4'hF) ? 4'hF : f[3:0] + 4'd1};
  endfunction

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      vld[i]  = fl[i][12];
      loc[i]  = fl[i][12] && (fl[i][7:4] == {addrx, addry});
      rank[i] = 2'd0;
      for (int j = 0; j < NP; j++) begin
        if (j != i && fl[j][12] && beats(fl[j], fl[i], j < i)) rank[i] = rank[i] + 2'd1;
      end
    end
  end

  // Any local flit guarantees one ejection, which frees a slot for injection.
  assign inj_ready = !(&vld) || (|loc);
  assign inj_go    = inj_valid && inj_ready;

  always_comb begin
    free    = 4'hF;
    ej_free = 1'b1;
    ndefl   = 3'd0;
    prod    = 4'h0;
    port    = 2'd0;
    eject_d = 13'h0000;
    for (int k = 0; k < NP; k++) out_d[k] = 13'h0000;

    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < NP; i++) begin
        if (vld[i] && rank[i] == 2'(p)) begin
          if (loc[i] && ej_free) begin
            ej_free = 1'b0;
            eject_d = fl[i];
          end else begin
            prod = loc[i] ? 4'h0 : (rm[i] & free);
            if (prod != 4'h0) begin
              port = first_set(prod);
            end else begin
              port  = first_set(free);
              ndefl = ndefl + 3'd1;
            end
            out_d[port] = age_inc(fl[i]);
            free[port]  = 1'b0;
          end
        end
      end
    end

    if (inj_go) begin
      prod = inj_rm & free;
      if (prod != 4'h0) begin
        port = first_set(prod);
      end else begin
        port  = first_set(free);
        ndefl = ndefl + 3'd1;
      end
      out_d[port] = {1'b1, inj_flit[11:4], 4'd1};
      free[port]  = 1'b0;
    end
  end

  assign defl_sum = {1'b0, defl_q} + {14'd0, ndefl};
  assign defl_d   = defl_sum[16] ? 16'hFFFF : defl_sum[15:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NP; k++) out_q[k] <= 13'h0000;
      eject_q <= 13'h0000;
      defl_q  <= 16'h0000;
    end else begin
      for (int k = 0; k < NP; k++) out_q[k] <= out_d[k];
      eject_q <= eject_d;
      defl_q  <= defl_d;
    end
  end

  assign out_n         = out_q[0];
  assign out_s         = out_q[1];
  assign out_e         = out_q[2];
  assign out_w         = out_q[3];
  assign eject_flit    = eject_q;
  assign deflect_count = defl_q;

endmodule

// File: tb/tb_bless_port_alloc.sv
// Directed bench for bless_port_alloc: expected outputs are queued at drive time and
// compared one cycle later when the registered outputs appear.
module tb_bless_port_alloc;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  addrx, addry;
  logic [12:0] in_n, in_s, in_e, in_w, inj_flit;
  logic [3:0]  rm_n, rm_s, rm_e, rm_w, inj_rm;
  logic        inj_valid, inj_ready;
  logic [12:0] out_n, out_s, out_e, out_w, eject_flit;
  logic [15:0] deflect_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [12:0] n, s, e, w, ej;
    logic [15:0] dc;
  } exp_t;
  exp_t  sb[$];
  string sb_tag[$];
  logic [15:0] exp_dc;

  bless_port_alloc dut (
    .clock(clock), .reset(reset), .addrx(addrx), .addry(addry),
    .in_n(in_n), .in_s(in_s), .in_e(in_e), .in_w(in_w),
    .rm_n(rm_n), .rm_s(rm_s), .rm_e(rm_e), .rm_w(rm_w),
    .inj_flit(inj_flit), .inj_rm(inj_rm), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .out_n(out_n), .out_s(out_s), .out_e(out_e), .out_w(out_w),
    .eject_flit(eject_flit), .deflect_count(deflect_count)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    in_n = '0; in_s = '0; in_e = '0; in_w = '0;
    rm_n = '0; rm_s = '0; rm_e = '0; rm_w = '0;
    inj_flit = '0; inj_rm = '0; inj_valid = 1'b0;
  endtask

  task automatic push(input string tag, input logic [12:0] n, input logic [12:0] s,
                      input logic [12:0] e, input logic [12:0] w, input logic [12:0] ej,
                      input logic [15:0] dc);
    exp_t x;
    x.n = n; x.s = s; x.e = e; x.w = w; x.ej = ej; x.dc = dc;
    sb.push_back(x);
    sb_tag.push_back(tag);
  endtask

  task automatic step();
    exp_t  x;
    string t;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      x = sb.pop_front();
      t = sb_tag.pop_front();
      chk({t, ".out_n"}, {3'b0, out_n}, {3'b0, x.n});
      chk({t, ".out_s"}, {3'b0, out_s}, {3'b0, x.s});
      chk({t, ".out_e"}, {3'b0, out_e}, {3'b0, x.e});
      chk({t, ".out_w"}, {3'b0, out_w}, {3'b0, x.w});
      chk({t, ".eject"}, {3'b0, eject_flit}, {3'b0, x.ej});
      chk({t, ".defl"},  deflect_count, x.dc);
    end
  endtask

  initial begin
    addrx = 2'b01; addry = 2'b01;
    clear_inputs();
    reset = 1'b1;
    exp_dc = 16'd0;

    // Reset: a valid input during reset must not be forwarded.
    in_n = 13'b1_1010_0000_0101; rm_n = 4'b0001;
    @(posedge clock); #1;
    push("reset", '0, '0, '0, '0, '0, 16'd0);
    step();
    reset = 1'b0;
    clear_inputs();

    // 1: single productive flit
    in_n = 13'b1_1010_0000_0101; rm_n = 4'b1001;
    #1 chk("single.inj_ready", {15'b0, inj_ready}, 16'd1);
    push("single", 13'b1_1010_0000_0110, '0, '0, '0, '0, exp_dc);
    step();
    clear_inputs();

    // 2: conflict resolved by age
    in_e = 13'b1_0000_0000_0101; rm_e = 4'b0001;
    in_w = 13'b1_0000_0000_0011; rm_w = 4'b0001;
    exp_dc = exp_dc + 16'd1;
    push("age", 13'b1_0000_0000_0110, 13'b1_0000_0000_0100, '0, '0, '0, exp_dc);
    step();
    clear_inputs();

    // 3: equal age, lower src wins
    in_n = 13'b1_0011_1101_0100; rm_n = 4'b0100;
    in_s = 13'b1_1000_1101_0100; rm_s = 4'b0100;
    exp_dc = exp_dc + 16'd1;
    push("src_tie", 13'b1_1000_1101_0101, '0, 13'b1_0011_1101_0101, '0, '0, exp_dc);
    step();
    clear_inputs();

    // 4: two local flits contend for eject
    in_n = 13'b1_0000_0101_0010;
    in_s = 13'b1_0000_0101_0111;
    #1 chk("eject.inj_ready", {15'b0, inj_ready}, 16'd1);
    exp_dc = exp_dc + 16'd1;
    push("eject", 13'b1_0000_0101_0011, '0, '0, '0, 13'b1_0000_0101_0111, exp_dc);
    step();
    clear_inputs();

    // 5a: four non-local valid inputs block injection
    in_n = 13'b1_0000_1111_0001; rm_n = 4'b0001;
    in_s = 13'b1_0000_1111_0001; rm_s = 4'b0010;
    in_e = 13'b1_0000_1111_0001; rm_e = 4'b0100;
    in_w = 13'b1_0000_1111_0001; rm_w = 4'b1000;
    inj_flit = 13'b1_0110_1010_1001; inj_rm = 4'b1000; inj_valid = 1'b1;
    #1 chk("full.inj_ready", {15'b0, inj_ready}, 16'd0);
    push("full", 13'b1_0000_1111_0010, 13'b1_0000_1111_0010, 13'b1_0000_1111_0010,
         13'b1_0000_1111_0010, '0, exp_dc);
    step();

    // 5b: W drops out, injection takes W with age 1
    in_w = '0; rm_w = 4'b1000;
    #1 chk("inj.inj_ready", {15'b0, inj_ready}, 16'd1);
    push("inject", 13'b1_0000_1111_0010, 13'b1_0000_1111_0010, 13'b1_0000_1111_0010,
         13'b1_0110_1010_0001, '0, exp_dc);
    step();
    clear_inputs();

    // 5c: local-destined injection with no productive port: deflected, never ejected
    inj_flit = 13'b0_0110_0101_0111; inj_rm = 4'b0000; inj_valid = 1'b1;
    exp_dc = exp_dc + 16'd1;
    push("inj_defl", 13'b1_0110_0101_0001, '0, '0, '0, '0, exp_dc);
    step();
    clear_inputs();

    // 5d: four valid with one local still admits injection
    in_n = 13'b1_0000_1111_0001; rm_n = 4'b0001;
    in_s = 13'b1_0000_0101_0001;
    in_e = 13'b1_0000_1111_0001; rm_e = 4'b0100;
    in_w = 13'b1_0000_1111_0001; rm_w = 4'b1000;
    inj_flit = 13'b1_0001_1111_0000; inj_rm = 4'b0010; inj_valid = 1'b1;
    #1 chk("onelocal.inj_ready", {15'b0, inj_ready}, 16'd1);
    push("onelocal", 13'b1_0000_1111_0010, 13'b1_0001_1111_0001, 13'b1_0000_1111_0010,
         13'b1_0000_1111_0010, 13'b1_0000_0101_0001, exp_dc);
    step();
    clear_inputs();

    // 6a: age saturation
    in_s = 13'b1_0001_0010_1111; rm_s = 4'b0010;
    push("age_sat", '0, 13'b1_0001_0010_1111, '0, '0, '0, exp_dc);
    step();
    clear_inputs();

    // 6b: drive deflect_count toward saturation with 4 deflections per cycle
    in_n = 13'b1_0000_1111_0000;
    in_s = 13'b1_0000_1111_0000;
    in_e = 13'b1_0000_1111_0000;
    in_w = 13'b1_0000_1111_0000;
    while (exp_dc < 16'hFFF0) begin
      @(posedge clock); #1;
      exp_dc = exp_dc + 16'd4;
    end
    for (int k = 0; k < 5; k++) begin
      exp_dc = (exp_dc >= 16'hFFFC) ? 16'hFFFF : exp_dc + 16'd4;
      push("defl_sat", 13'b1_0000_1111_0001, 13'b1_0000_1111_0001, 13'b1_0000_1111_0001,
           13'b1_0000_1111_0001, '0, exp_dc);
      step();
    end

    // 6c: reset mid-stream clears everything, then allocation resumes
    reset = 1'b1;
    exp_dc = 16'd0;
    push("mid_reset", '0, '0, '0, '0, '0, exp_dc);
    step();
    reset = 1'b0;
    clear_inputs();
    in_e = 13'b1_0010_0000_0011; rm_e = 4'b0100;
    push("resume", '0, '0, 13'b1_0010_0000_0100, '0, '0, exp_dc);
    step();
    clear_inputs();

    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bless_port_alloc.md
# bless_port_alloc

Output-port allocator for the bufferless (BLESS) router. Each cycle it takes up to four incoming flits (N, S, E, W), their productive-direction matrices from the per-port route-compute units, and one optional injection flit. It ranks the flits oldest-first, ejects at most one flit destined for this node, assigns every other flit an output port (productive if one is free, otherwise a deflection), and registers the result. No flit is ever buffered or dropped: every valid input leaves on an output or the eject port one cycle later.

## Interface
- No parameters. Flit width is fixed at 13 bits: {valid[12], src[11:8], dst[7:4], age[3:0]}. src and dst are {x[1:0], y[1:0]}.
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- addrx, addry  in  2 each  this router's coordinates
- in_n, in_s, in_e, in_w  in  13 each  incoming flits
- rm_n, rm_s, rm_e, rm_w  in  4 each  productive directions per input; bit0 N, bit1 S, bit2 E, bit3 W
- inj_flit  in  13  local injection flit; age field ignored, treated as 0
- inj_rm  in  4  productive directions for inj_flit
- inj_valid  in  1  injection request
- inj_ready  out  1  combinational; injection slot available this cycle
- out_n, out_s, out_e, out_w  out  13 each  registered output flits
- eject_flit  out  13  registered ejected flit; valid bit marks it
- deflect_count  out  16  saturating count of deflected flits

## Operation
- Input i is valid when in_i[12]=1. An invalid input's other bits and its rm_i are ignored.
- An input is local when valid and dst == {addrx, addry}.
- **Ranking:** higher age first. On equal age, lower src wins. On equal src, fixed port order N > S > E > W.
- **Allocation:** flits are processed in rank order. The outputs are N, S, E, W plus one eject slot.
  - A local flit takes the eject slot if it is still free.
  - Otherwise the flit takes the lowest-index free output whose rm bit is set (N before S before E before W).
  - If no such output is free, the flit takes the lowest-index free output. This is a deflection.
  - A local flit that loses ejection is always deflected, and counts as a deflection.
- **Injection:** inj_ready = 1 when (valid inputs − local flits that will eject) < 4. It is independent of inj_valid.
  - A transfer occurs when inj_valid && inj_ready at the rising edge.
  - The injected flit is allocated after all incoming flits, using the same productive/deflect rule with inj_rm.
  - An injection that lands on a non-productive port counts as a deflection.
  - Injection never uses the eject slot, even if inj_flit's dst is local.
- **Age:** every flit written to out_* has its age incremented by 1, saturating at 4'hF. An injected flit leaves with age 1. eject_flit carries its age unchanged.
- **Idle slots:** unassigned outputs and an unused eject slot are driven 13'h0000.
- **deflect_count:** adds the number of deflections made this cycle (0–4) and saturates at 16'hFFFF.

## Timing
- Allocation is combinational from the current inputs. out_*, eject_flit and deflect_count update on the rising edge, so latency is exactly 1 cycle.
- inj_ready is a combinational function of in_*, addrx and addry only. There is no path from inj_valid to inj_ready.
- Full throughput: a new set of flits is accepted every cycle, with no stall and no backpressure on in_*.
- **Reset:** out_n/s/e/w and eject_flit = 13'h0000, deflect_count = 0. Flits in flight when reset asserts are discarded. Inputs presented during reset are not forwarded. Allocation resumes in the first cycle after reset deasserts.
- **Edge cases:**
  - Four valid inputs with none local: inj_ready = 0.
  - Four valid inputs with one local: inj_ready = 1.
  - At most one eject per cycle.
  - Exactly one output is driven per valid flit. No output is ever written twice.

## Test plan
All scenarios use addrx = addry = 2'b01.

1. **Single productive flit:** in_n = 13'b1_1010_0000_0101, rm_n = 4'b1001 → next cycle out_n = 13'b1_1010_0000_0110, all other outputs 0, deflect_count unchanged.
2. **Conflict by age:** in_e = 1_0000_0000_0101 with rm_e = 0001; in_w = 1_0000_0000_0011 with rm_w = 0001 → out_n has age 6 (from E), out_s has age 4 (from W), deflect_count + 1.
3. **Age tie broken by src:**
   - Stimulus: in_n = 1_0011_1101_0100 and in_s = 1_1000_1101_0100, both with rm = 0100.
   - Expected: the src 0011 flit goes to out_e and the src 1000 flit is deflected to out_n.
4. **Ejection contention:**
   - Stimulus: in_n = 1_0000_0101_0010 and in_s = 1_0000_0101_0111, both with rm = 0000.
   - Expected: eject_flit = 1_0000_0101_0111; the age-2 flit goes to out_n with age 3; deflect_count + 1.
5. **Injection:**
   - Four non-local valid inputs → inj_ready = 0 and the injection is not consumed.
   - Drop in_w to invalid → inj_ready = 1. inj_flit with inj_rm = 1000 appears on out_w with age 1, assuming no incoming flit claimed W.
6. **Saturation and reset:**
   - An age-15 flit is forwarded with age 15.
   - Preload deflect_count near 16'hFFFF with repeated 4-deflection cycles → it holds at 16'hFFFF.
   - Assert reset mid-stream → all outputs 0 on the next edge.
